// File: rtl/floating_point_sign_restore.sv
// Sign-restoration stage for the odd-symmetric (tanh) PWL path: queues operand signs in
// issue order and re-applies each one to the matching PWL result f(|x|).
module floating_point_sign_restore #(
    parameter int DATA_WIDTH = 5,
    parameter int DEPTH      = 4,
    parameter int ZERO_POS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_x,
    input  logic                         y_valid,
    output logic                         y_ready,
    input  logic [DATA_WIDTH-1:0]        y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_y,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic                  sign_mem [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  err_reg;
    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_y_reg;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  pop_sign;
    logic [DATA_WIDTH-1:0] restored;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // Ready depends only on registered state, reset and out_ready, never on the valids.
    assign in_ready = !full && !rst;
    assign y_ready  = !empty && (!out_valid_reg || out_ready) && !rst;

    assign push     = in_valid && in_ready;
    assign pop      = y_valid && y_ready;
    assign pop_sign = sign_mem[rd_ptr_reg];

    generate
        if (ZERO_POS != 0) begin : g_zero_pos
            always_comb begin
                restored = {y[DATA_WIDTH-1] ^ pop_sign, y[DATA_WIDTH-2:0]};
                // A zero magnitude is forced to +0 so the result never carries -0.
                if (y[DATA_WIDTH-2:0] == '0) begin
                    restored = '0;
                end
            end
        end else begin : g_signed_zero
            assign restored = {y[DATA_WIDTH-1] ^ pop_sign, y[DATA_WIDTH-2:0]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            sign_mem[wr_ptr_reg] <= in_x[DATA_WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_y_reg     <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
            if (y_valid && empty) begin
                err_reg <= 1'b1;
            end
            if (pop) begin
                out_y_reg     <= restored;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_y     = out_y_reg;
    assign count     = count_reg;
    assign err       = err_reg;
endmodule

// File: tb/tb_floating_point_sign_restore.sv
// Directed bench for floating_point_sign_restore; a second instance with ZERO_POS=0
// shares all inputs so the signed-zero behaviour is checked alongside the default.
module tb_floating_point_sign_restore;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready, in_ready_b;
    logic [4:0] in_x;
    logic       y_valid;
    logic       y_ready, y_ready_b;
    logic [4:0] y;
    logic       out_valid, out_valid_b;
    logic       out_ready;
    logic [4:0] out_y, out_y_b;
    logic [2:0] count, count_b;
    logic       err, err_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    floating_point_sign_restore #(.DATA_WIDTH(5), .DEPTH(4), .ZERO_POS(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .y_valid(y_valid), .y_ready(y_ready), .y(y),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .count(count), .err(err)
    );

    floating_point_sign_restore #(.DATA_WIDTH(5), .DEPTH(4), .ZERO_POS(0)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_x(in_x),
        .y_valid(y_valid), .y_ready(y_ready_b), .y(y),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_y(out_y_b),
        .count(count_b), .err(err_b)
    );

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            $display("out transaction: out_y=%b count=%0d err=%0b", out_y, count, err);
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; y_valid = 1'b0; y = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_out_y", 8'(out_y), 8'd0);
        check("rst_count", 8'(count), 8'd0);
        check("rst_err", 8'(err), 8'd0);
        check("rst_in_ready", 8'(in_ready), 8'd0);
        check("rst_y_ready", 8'(y_ready), 8'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 8'(in_ready), 8'd1);
        check("idle_y_ready", 8'(y_ready), 8'd0);

        // Basic sign restore
        in_valid = 1'b1; in_x = 5'b10110;
        tick();
        in_valid = 1'b0;
        check("basic_count1", 8'(count), 8'd1);
        y_valid = 1'b1; y = 5'b01010;
        check("basic_y_ready", 8'(y_ready), 8'd1);
        tick();
        y_valid = 1'b0;
        check("basic_out_valid", 8'(out_valid), 8'd1);
        check("basic_out_y", 8'(out_y), 8'b11010);
        check("basic_count0", 8'(count), 8'd0);
        tick();
        check("basic_out_clear", 8'(out_valid), 8'd0);

        // Positive pass-through, then zero magnitude with negative sign
        in_valid = 1'b1; in_x = 5'b00011;
        tick();
        in_valid = 1'b0; y_valid = 1'b1; y = 5'b01100;
        tick();
        y_valid = 1'b0;
        check("pos_out_y", 8'(out_y), 8'b01100);
        check("pos_out_y_b", 8'(out_y_b), 8'b01100);
        in_valid = 1'b1; in_x = 5'b10001;
        tick();
        in_valid = 1'b0; y_valid = 1'b1; y = 5'b00000;
        tick();
        y_valid = 1'b0;
        check("zero_out_valid", 8'(out_valid), 8'd1);
        check("zero_out_y_zpos1", 8'(out_y), 8'b00000);
        check("zero_out_y_zpos0", 8'(out_y_b), 8'b10000);
        tick();

        // Fill to full with signs 1,0,1,1
        in_valid = 1'b1; in_x = 5'b10000; tick();
        in_x = 5'b00000; tick();
        in_x = 5'b10000; tick();
        check("fill_count3", 8'(count), 8'd3);
        in_x = 5'b10000; tick();
        check("full_count", 8'(count), 8'd4);
        check("full_in_ready", 8'(in_ready), 8'd0);
        in_x = 5'b00000; tick();
        check("full_push_refused", 8'(count), 8'd4);
        // Pop while full with push still requested: push must not be taken
        y_valid = 1'b1; y = 5'b00101;
        tick();
        in_valid = 1'b0;
        check("full_pop_count", 8'(count), 8'd3);
        check("order_0", 8'(out_y), 8'b10101);
        tick();
        check("order_1", 8'(out_y), 8'b00101);
        tick();
        check("order_2", 8'(out_y), 8'b10101);
        tick();
        y_valid = 1'b0;
        check("order_3", 8'(out_y), 8'b10101);
        check("order_count0", 8'(count), 8'd0);
        tick();
        check("order_out_clear", 8'(out_valid), 8'd0);

        // Backpressure
        in_valid = 1'b1; in_x = 5'b10000; tick();
        in_x = 5'b00000; tick();
        in_valid = 1'b0;
        out_ready = 1'b0; y_valid = 1'b1; y = 5'b00111;
        tick();
        check("bp_out_valid", 8'(out_valid), 8'd1);
        check("bp_out_y", 8'(out_y), 8'b10111);
        check("bp_y_ready", 8'(y_ready), 8'd0);
        tick(); tick();
        check("bp_hold_out_y", 8'(out_y), 8'b10111);
        check("bp_hold_valid", 8'(out_valid), 8'd1);
        check("bp_hold_count", 8'(count), 8'd1);
        out_ready = 1'b1;
        #1;
        check("bp_release_y_ready", 8'(y_ready), 8'd1);
        tick();
        y_valid = 1'b0;
        check("bp_second_out_y", 8'(out_y), 8'b00111);
        check("bp_second_valid", 8'(out_valid), 8'd1);
        check("bp_count0", 8'(count), 8'd0);
        tick();
        check("bp_out_clear", 8'(out_valid), 8'd0);

        // Underflow: sticky err, result not consumed
        y_valid = 1'b1; y = 5'b00011;
        check("uf_y_ready", 8'(y_ready), 8'd0);
        tick();
        y_valid = 1'b0;
        check("uf_err", 8'(err), 8'd1);
        check("uf_no_out", 8'(out_valid), 8'd0);
        tick();
        check("uf_err_sticky", 8'(err), 8'd1);

        // Reset mid-stream with 3 signs stored and a pending result
        in_valid = 1'b1; in_x = 5'b10000;
        tick(); tick(); tick(); tick();
        in_valid = 1'b0;
        out_ready = 1'b0; y_valid = 1'b1; y = 5'b00001;
        tick();
        y_valid = 1'b0;
        check("pre_rst_count", 8'(count), 8'd3);
        check("pre_rst_valid", 8'(out_valid), 8'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_count", 8'(count), 8'd0);
        check("mid_rst_valid", 8'(out_valid), 8'd0);
        check("mid_rst_err", 8'(err), 8'd0);
        check("mid_rst_in_ready", 8'(in_ready), 8'd0);
        rst = 1'b0; out_ready = 1'b1;
        tick();
        check("post_rst_in_ready", 8'(in_ready), 8'd1);
        check("post_rst_y_ready", 8'(y_ready), 8'd0);

        // Wrap-around: 10 back-to-back push/pop pairs, alternating sign
        in_valid = 1'b1; in_x = 5'b00000; y_valid = 1'b0;
        tick();
        for (int k = 1; k < 10; k++) begin
            in_x = {1'(k & 1), 4'b0000};
            y_valid = 1'b1; y = 5'b00110;
            tick();
            check($sformatf("wrap_out_y_%0d", k), 8'(out_y), 8'({1'((k - 1) & 1), 4'b0110}));
            check($sformatf("wrap_count_%0d", k), 8'(count), 8'd1);
            check($sformatf("wrap_valid_%0d", k), 8'(out_valid), 8'd1);
        end
        in_valid = 1'b0;
        tick();
        y_valid = 1'b0;
        check("wrap_last_out_y", 8'(out_y), 8'b10110);
        check("wrap_last_count", 8'(count), 8'd0);
        check("wrap_err", 8'(err), 8'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
